// File: rtl/udma_adc_scan_ctrl.sv
// ---------------------------------------------------------------------------
// udma_adc_scan_ctrl
//
// Conversion scheduler for the uDMA ADC receive path. A period timer
// raises a scan trigger. Each scan walks the enabled-channel mask from the
// lowest set bit upwards. For each channel the block selects the channel,
// pulses a conversion start and waits for the synchronised done strobe.
// It then presents the channel-tagged sample to the uDMA RX stream through
// a valid/ready handshake. The channel is dropped if the ADC does not
// answer within TIMEOUT cycles.
//
// Ports
//   sys_clk_i, rst_ni     clock, synchronous active-low reset
//   cfg_en_i              scan enable (level); low holds the timer at 0
//   cfg_single_i          1: one scan per enable, 0: periodic scans
//   cfg_ch_mask_i         enabled channels, latched at scan start
//   cfg_period_i          trigger period minus 1, in cycles
//   cfg_err_clr_i         clears both sticky error flags
//   adc_ch_sel_o          channel select, stable while a channel is active
//   adc_start_o           one-cycle conversion start pulse
//   adc_done_i            one-cycle conversion-done strobe (synchronised)
//   adc_data_i            sample, valid in the adc_done_i cycle
//   data_rx_o             {channel[7:0], zero pad, sample}
//   data_rx_valid_o       sample available to uDMA
//   data_rx_ready_i       uDMA accepts sample
//   busy_o                scan in progress (state is not IDLE)
//   scan_done_o           one-cycle pulse at the end of each scan
//   err_timeout_o         sticky: a conversion timed out
//   err_overrun_o         sticky: a trigger arrived while scanning
// ---------------------------------------------------------------------------
module udma_adc_scan_ctrl #(
    parameter int NUM_CH         = 4,
    parameter int ADC_DATA_WIDTH = 16,
    parameter int TIMER_WIDTH    = 16,
    parameter int TIMEOUT        = 255
) (
    input  logic                        sys_clk_i,
    input  logic                        rst_ni,
    input  logic                        cfg_en_i,
    input  logic                        cfg_single_i,
    input  logic [NUM_CH-1:0]           cfg_ch_mask_i,
    input  logic [TIMER_WIDTH-1:0]      cfg_period_i,
    input  logic                        cfg_err_clr_i,
    output logic [$clog2(NUM_CH)-1:0]   adc_ch_sel_o,
    output logic                        adc_start_o,
    input  logic                        adc_done_i,
    input  logic [ADC_DATA_WIDTH-1:0]   adc_data_i,
    output logic [31:0]                 data_rx_o,
    output logic                        data_rx_valid_o,
    input  logic                        data_rx_ready_i,
    output logic                        busy_o,
    output logic                        scan_done_o,
    output logic                        err_timeout_o,
    output logic                        err_overrun_o
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_PUSH,
        S_NEXT
    } state_e;

    state_e                   state_q, state_d;
    logic [TIMER_WIDTH-1:0]   timer_q, timer_d;
    logic [NUM_CH-1:0]        mask_q, mask_d;
    logic [CH_W-1:0]          ptr_q, ptr_d;
    logic [TO_W-1:0]          to_cnt_q, to_cnt_d;
    logic [31:0]              data_q, data_d;
    logic                     err_to_q, err_to_d;
    logic                     err_ov_q, err_ov_d;
    logic                     single_done_q, single_done_d;

    logic                     trig;
    logic                     to_set;
    logic [CH_W-1:0]          first_idx, next_idx;
    logic                     first_ok, next_ok;
    logic [31:0]              rx_word;

    // ---------------------------------------------------------------------
    // Period timer: counts 0..cfg_period_i, trigger on the terminal count.
    // ---------------------------------------------------------------------
    assign trig = cfg_en_i && (timer_q == cfg_period_i);

    always_comb begin
        if (!cfg_en_i || trig) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TIMER_WIDTH'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Channel search. Iterating downwards leaves the lowest qualifying
    // index in the result.
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise a path that skips the assignment infers a latch.
        first_idx = '0;
        first_ok  = 1'b0;
        next_idx  = '0;
        next_ok   = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (cfg_ch_mask_i[i]) begin
                first_idx = CH_W'(i);
                first_ok  = 1'b1;
            end
            if (mask_q[i] && (i > int'(ptr_q))) begin
                next_idx = CH_W'(i);
                next_ok  = 1'b1;
            end
        end
    end

    // Channel tag in [31:24], sample in the low bits, zero in between.
    always_comb begin
        rx_word                      = '0;
        rx_word[31:24]               = 8'(ptr_q);
        rx_word[ADC_DATA_WIDTH-1:0]  = adc_data_i;
    end

    // ---------------------------------------------------------------------
    // Scan FSM: next state and outputs.
    // ---------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        mask_d          = mask_q;
        ptr_d           = ptr_q;
        to_cnt_d        = to_cnt_q;
        data_d          = data_q;
        to_set          = 1'b0;
        // The single-scan lockout is released as soon as enable is seen low.
        single_done_d   = cfg_en_i ? single_done_q : 1'b0;
        adc_start_o     = 1'b0;
        data_rx_valid_o = 1'b0;
        scan_done_o     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (trig && first_ok && !(cfg_single_i && single_done_q)) begin
                    mask_d  = cfg_ch_mask_i;
                    ptr_d   = first_idx;
                    state_d = S_START;
                end
            end
            S_START: begin
                adc_start_o = 1'b1;
                to_cnt_d    = '0;
                state_d     = cfg_en_i ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (!cfg_en_i) begin
                    state_d = S_IDLE;
                end else if (adc_done_i) begin
                    data_d  = rx_word;
                    state_d = S_PUSH;
                end else if (to_cnt_q == TO_W'(TIMEOUT)) begin
                    to_set  = 1'b1;
                    state_d = S_NEXT;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_PUSH: begin
                // Valid is held until accepted, even if enable drops.
                data_rx_valid_o = 1'b1;
                if (data_rx_ready_i) begin
                    state_d = cfg_en_i ? S_NEXT : S_IDLE;
                end
            end
            S_NEXT: begin
                if (next_ok) begin
                    ptr_d   = next_idx;
                    state_d = S_START;
                end else begin
                    scan_done_o = 1'b1;
                    state_d     = S_IDLE;
                    if (cfg_single_i && cfg_en_i) begin
                        single_done_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sticky flags: a set in the same cycle as a clear wins.
    always_comb begin
        err_to_d = to_set ? 1'b1 : (cfg_err_clr_i ? 1'b0 : err_to_q);
        err_ov_d = (trig && (state_q != S_IDLE)) ? 1'b1
                 : (cfg_err_clr_i ? 1'b0 : err_ov_q);
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge sys_clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            mask_q        <= '0;
            ptr_q         <= '0;
            to_cnt_q      <= '0;
            // NOTE: the sample register is reset even though it is only
            // read while valid, because data_rx_o must read 0 after reset.
            data_q        <= '0;
            err_to_q      <= 1'b0;
            err_ov_q      <= 1'b0;
            single_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            mask_q        <= mask_d;
            ptr_q         <= ptr_d;
            to_cnt_q      <= to_cnt_d;
            data_q        <= data_d;
            err_to_q      <= err_to_d;
            err_ov_q      <= err_ov_d;
            single_done_q <= single_done_d;
        end
    end

    assign adc_ch_sel_o  = ptr_q;
    assign data_rx_o     = data_q;
    assign busy_o        = (state_q != S_IDLE);
    assign err_timeout_o = err_to_q;
    assign err_overrun_o = err_ov_q;

endmodule

// File: tb/tb_udma_adc_scan_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for udma_adc_scan_ctrl. The stimulus pushes hand-computed
// expected RX words into a queue. A monitor on the falling edge pops and
// compares one entry per accepted word. It also tracks start pulses,
// scan_done pulses, the timeout rise and backpressure stability.
// A small ADC model answers start pulses with per-channel table data.
// ---------------------------------------------------------------------------
module tb_udma_adc_scan_ctrl;

    localparam int NUM_CH = 4;
    localparam int DW     = 16;
    localparam int TW     = 16;
    localparam int TO     = 8;

    logic           sys_clk_i = 1'b0;
    logic           rst_ni;
    logic           cfg_en_i;
    logic           cfg_single_i;
    logic [3:0]     cfg_ch_mask_i;
    logic [TW-1:0]  cfg_period_i;
    logic           cfg_err_clr_i;
    logic [1:0]     adc_ch_sel_o;
    logic           adc_start_o;
    logic           adc_done_i;
    logic [DW-1:0]  adc_data_i;
    logic [31:0]    data_rx_o;
    logic           data_rx_valid_o;
    logic           data_rx_ready_i;
    logic           busy_o;
    logic           scan_done_o;
    logic           err_timeout_o;
    logic           err_overrun_o;

    udma_adc_scan_ctrl #(
        .NUM_CH         (NUM_CH),
        .ADC_DATA_WIDTH (DW),
        .TIMER_WIDTH    (TW),
        .TIMEOUT        (TO)
    ) dut (
        .sys_clk_i       (sys_clk_i),
        .rst_ni          (rst_ni),
        .cfg_en_i        (cfg_en_i),
        .cfg_single_i    (cfg_single_i),
        .cfg_ch_mask_i   (cfg_ch_mask_i),
        .cfg_period_i    (cfg_period_i),
        .cfg_err_clr_i   (cfg_err_clr_i),
        .adc_ch_sel_o    (adc_ch_sel_o),
        .adc_start_o     (adc_start_o),
        .adc_done_i      (adc_done_i),
        .adc_data_i      (adc_data_i),
        .data_rx_o       (data_rx_o),
        .data_rx_valid_o (data_rx_valid_o),
        .data_rx_ready_i (data_rx_ready_i),
        .busy_o          (busy_o),
        .scan_done_o     (scan_done_o),
        .err_timeout_o   (err_timeout_o),
        .err_overrun_o   (err_overrun_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [31:0] exp_q[$];
    int          start_cyc[$];
    int          cyc = 0;
    int          words_acc = 0;
    int          done_cnt = 0;
    int          start_cnt = 0;
    int          last_start_cyc = 0;
    int          err_rise_delay = -1;
    logic        prev_rst = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic        prev_err = 1'b0;
    logic [31:0] prev_data = '0;

    always @(negedge sys_clk_i) begin
        cyc++;
        if (rst_ni) begin
            if (adc_start_o) begin
                start_cnt++;
                start_cyc.push_back(cyc);
                last_start_cyc = cyc;
            end
            if (scan_done_o) done_cnt++;
            if (err_timeout_o && !prev_err) err_rise_delay = cyc - last_start_cyc;
            if (prev_rst && prev_valid && !prev_ready) begin
                check("valid_hold", {31'b0, data_rx_valid_o}, 32'd1);
                check("data_hold", data_rx_o, prev_data);
            end
            if (data_rx_valid_o && data_rx_ready_i) begin
                words_acc++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got 0x%08h, expected no word", data_rx_o);
                end else begin
                    check("word", data_rx_o, exp_q.pop_front());
                end
            end
        end
        prev_rst   = rst_ni;
        prev_valid = data_rx_valid_o;
        prev_ready = data_rx_ready_i;
        prev_err   = err_timeout_o;
        prev_data  = data_rx_o;
    end

    // ---------------- ADC model ----------------
    logic [DW-1:0] adc_tbl [4];
    logic [3:0]    adc_mute;
    int            adc_lat;
    logic [1:0]    adc_ch_l;

    initial begin
        adc_done_i = 1'b0;
        adc_data_i = '0;
        forever begin
            @(negedge sys_clk_i);
            if (rst_ni && adc_start_o && !adc_mute[adc_ch_sel_o]) begin
                adc_ch_l = adc_ch_sel_o;
                repeat (adc_lat) @(posedge sys_clk_i);
                #1;
                adc_done_i = 1'b1;
                adc_data_i = adc_tbl[adc_ch_l];
                @(posedge sys_clk_i);
                #1;
                adc_done_i = 1'b0;
                adc_data_i = '0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge sys_clk_i);
            #1;
        end
    endtask

    // which: 0 = scan_done_o, 1 = data_rx_valid_o, 2 = adc_start_o
    task automatic wait_sig(input string name, input int which, input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge sys_clk_i);
            case (which)
                0:       seen = scan_done_o;
                1:       seen = data_rx_valid_o;
                default: seen = adc_start_o;
            endcase
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s: event not seen within %0d cycles", name, bound);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_busy"},  busy_o, 0);
        check({pfx, "_start"}, adc_start_o, 0);
        check({pfx, "_sel"},   adc_ch_sel_o, 0);
        check({pfx, "_data"},  data_rx_o, 0);
        check({pfx, "_valid"}, data_rx_valid_o, 0);
        check({pfx, "_done"},  scan_done_o, 0);
        check({pfx, "_eto"},   err_timeout_o, 0);
        check({pfx, "_eov"},   err_overrun_o, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    int base_w, base_s, s0, d0;

    initial begin
        rst_ni          = 1'b0;
        cfg_en_i        = 1'b0;
        cfg_single_i    = 1'b0;
        cfg_ch_mask_i   = '0;
        cfg_period_i    = '0;
        cfg_err_clr_i   = 1'b0;
        data_rx_ready_i = 1'b0;
        adc_lat         = 3;
        adc_mute        = '0;
        for (int i = 0; i < 4; i++) adc_tbl[i] = '0;

        step(3);
        check_all_zero("rst");
        rst_ni = 1'b1;
        step(2);

        // Two-channel periodic scan
        adc_tbl[0] = 16'h0ABC;
        adc_tbl[2] = 16'h0DEF;
        cfg_ch_mask_i   = 4'b0101;
        cfg_period_i    = 16'd99;
        data_rx_ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(32'h00000ABC);
            exp_q.push_back(32'h02000DEF);
        end
        base_w = words_acc;
        base_s = start_cyc.size();
        cfg_en_i = 1'b1;
        wait_sig("scan1_done", 0, 300);
        check("scan1_words", words_acc - base_w, 2);
        wait_sig("scan2_done", 0, 300);
        step();
        cfg_en_i = 1'b0;
        check("scan2_words", words_acc - base_w, 4);
        if (start_cyc.size() >= base_s + 3) begin
            check("period", start_cyc[base_s + 2] - start_cyc[base_s], 100);
        end else begin
            tests++;
            fails++;
            $display("FAIL period: got %0d starts, expected at least 3", start_cyc.size() - base_s);
        end
        check("scan_eov", err_overrun_o, 0);
        step(5);

        // Backpressure
        adc_tbl[0] = 16'h1234;
        cfg_ch_mask_i   = 4'b0001;
        cfg_period_i    = 16'd40;
        data_rx_ready_i = 1'b0;
        exp_q.push_back(32'h00001234);
        base_w = words_acc;
        cfg_en_i = 1'b1;
        wait_sig("bp_valid", 1, 200);
        s0 = start_cnt;
        step(20);
        check("bp_no_start", start_cnt - s0, 0);
        check("bp_valid", data_rx_valid_o, 1);
        check("bp_data", data_rx_o, 32'h00001234);
        check("bp_no_accept", words_acc - base_w, 0);
        data_rx_ready_i = 1'b1;
        step();
        check("bp_accept", words_acc - base_w, 1);
        check("bp_valid_drop", data_rx_valid_o, 0);
        wait_sig("bp_done", 0, 10);
        step();
        cfg_en_i = 1'b0;
        check("bp_eov", err_overrun_o, 0);
        step(5);

        // Timeout on channel 1
        adc_tbl[0] = 16'h0111;
        adc_mute       = 4'b0010;
        cfg_ch_mask_i  = 4'b0011;
        cfg_period_i   = 16'd60;
        exp_q.push_back(32'h00000111);
        base_w = words_acc;
        err_rise_delay = -1;
        cfg_en_i = 1'b1;
        wait_sig("to_done", 0, 300);
        step();
        cfg_en_i = 1'b0;
        check("to_words", words_acc - base_w, 1);
        check("to_delay", err_rise_delay, 10);
        check("to_flag", err_timeout_o, 1);
        cfg_err_clr_i = 1'b1;
        step();
        cfg_err_clr_i = 1'b0;
        check("to_clear", err_timeout_o, 0);
        adc_mute = '0;
        step(5);

        // Overrun with a slow ADC
        adc_lat    = 6;
        adc_tbl[0] = 16'h0222;
        cfg_ch_mask_i = 4'b0001;
        cfg_period_i  = 16'd2;
        exp_q.push_back(32'h00000222);
        exp_q.push_back(32'h00000222);
        s0 = start_cnt;
        base_w = words_acc;
        cfg_en_i = 1'b1;
        wait_sig("ov_done1", 0, 100);
        wait_sig("ov_done2", 0, 100);
        step();
        cfg_en_i = 1'b0;
        check("ov_flag", err_overrun_o, 1);
        check("ov_starts", start_cnt - s0, 2);
        check("ov_words", words_acc - base_w, 2);
        cfg_err_clr_i = 1'b1;
        step();
        cfg_err_clr_i = 1'b0;
        check("ov_clear", err_overrun_o, 0);
        step(5);

        // Single mode
        adc_lat    = 1;
        adc_tbl[0] = 16'h0055;
        cfg_single_i  = 1'b1;
        cfg_period_i  = 16'd9;
        exp_q.push_back(32'h00000055);
        s0 = start_cnt;
        cfg_en_i = 1'b1;
        wait_sig("single_done1", 0, 100);
        step(60);
        check("single_starts1", start_cnt - s0, 1);
        check("single_eov", err_overrun_o, 0);
        cfg_en_i = 1'b0;
        step(2);
        exp_q.push_back(32'h00000055);
        cfg_en_i = 1'b1;
        wait_sig("single_done2", 0, 100);
        step();
        check("single_starts2", start_cnt - s0, 2);
        cfg_en_i     = 1'b0;
        cfg_single_i = 1'b0;
        step(5);

        // Abort in WAIT
        adc_mute      = 4'b0001;
        cfg_period_i  = 16'd20;
        s0 = start_cnt;
        d0 = done_cnt;
        base_w = words_acc;
        cfg_en_i = 1'b1;
        wait_sig("abort_start", 2, 100);
        step(2);
        cfg_en_i = 1'b0;
        step();
        check("abort_idle", busy_o, 0);
        step(30);
        check("abort_words", words_acc - base_w, 0);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_no_eto", err_timeout_o, 0);
        check("abort_starts", start_cnt - s0, 1);
        adc_mute = '0;
        step(5);

        // Reset while a word waits in PUSH
        adc_tbl[2] = 16'h0777;
        cfg_ch_mask_i   = 4'b0100;
        data_rx_ready_i = 1'b0;
        cfg_en_i = 1'b1;
        wait_sig("rstpush_valid", 1, 100);
        step();
        check("rstpush_pre_data", data_rx_o, 32'h02000777);
        rst_ni = 1'b0;
        step();
        check_all_zero("rstpush");
        rst_ni          = 1'b1;
        cfg_en_i        = 1'b0;
        data_rx_ready_i = 1'b1;
        step(5);

        // Zero mask never starts
        cfg_ch_mask_i = 4'b0000;
        cfg_period_i  = 16'd3;
        s0 = start_cnt;
        d0 = done_cnt;
        cfg_en_i = 1'b1;
        step(40);
        check("m0_starts", start_cnt - s0, 0);
        check("m0_done", done_cnt - d0, 0);
        check("m0_busy", busy_o, 0);
        check("m0_eto", err_timeout_o, 0);
        check("m0_eov", err_overrun_o, 0);
        cfg_en_i = 1'b0;
        step(3);

        // Top channel only
        adc_lat    = 3;
        adc_tbl[3] = 16'h0F0F;
        cfg_ch_mask_i = 4'b1000;
        cfg_period_i  = 16'd30;
        exp_q.push_back(32'h03000F0F);
        base_w = words_acc;
        cfg_en_i = 1'b1;
        wait_sig("m8_done", 0, 200);
        step();
        cfg_en_i = 1'b0;
        check("m8_words", words_acc - base_w, 1);
        check("m8_sel", adc_ch_sel_o, 3);

        step(5);
        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
